// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC register, next-PC resolution and return stack.
// Tracks run/halt/fault state and counts retired instructions.
module fetch_sequencer #(
  parameter int PC_W        = 16,
  parameter int PROG_LEN    = 1024,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         Branch_abs,
  input  logic                         Branch_rel_z,
  input  logic                         Branch_rel_nz,
  input  logic                         Call,
  input  logic                         Ret,
  input  logic                         Halt,
  input  logic                         ALU_zero,
  input  logic [PC_W-1:0]              Target,
  output logic [PC_W-1:0]              PC,
  output logic                         DONE,
  output logic                         FAULT,
  output logic [15:0]                  instr_count,
  output logic [$clog2(STACK_DEPTH):0] sp
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [IDX_W:0] SP_MAX = (IDX_W+1)'(STACK_DEPTH);

  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic [IDX_W:0]   r_sp;
  logic [IDX_W-1:0] r_top;
  logic [15:0]      r_cnt;
  logic [PC_W-1:0]  r_stack [STACK_DEPTH];

  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_pc_rel;
  logic [IDX_W-1:0] w_top_m1;
  logic [PC_W-1:0]  w_next;
  logic             w_halt;
  logic             w_push;
  logic             w_pop;
  logic             w_uflow;
  logic             w_ovr;
  logic             w_fault;
  logic             w_run;

  assign w_pc_inc = r_pc + 1'b1;
  assign w_pc_rel = r_pc + Target;
  assign w_top_m1 = r_top - 1'b1;
  assign w_run    = (r_state == S_RUN);

  // Resolve next PC by priority; only the winning source acts.
  always_comb begin
    w_next  = w_pc_inc;
    w_halt  = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_uflow = 1'b0;
    if (Halt) begin
      w_halt = 1'b1;
      w_next = r_pc;
    end else if (Ret) begin
      if (r_sp == '0) begin
        w_uflow = 1'b1;
        w_next  = r_pc;
      end else begin
        w_pop  = 1'b1;
        w_next = r_stack[w_top_m1];
      end
    end else if (Call) begin
      w_push = 1'b1;
      w_next = Target;
    end else if (Branch_abs) begin
      w_next = Target;
    end else if (Branch_rel_z && ALU_zero) begin
      w_next = w_pc_rel;
    end else if (Branch_rel_nz && !ALU_zero) begin
      w_next = w_pc_rel;
    end
  end

  // Overrun only matters when the PC actually moves.
  assign w_ovr   = !w_halt && !w_uflow &&
                   (32'(w_next) >= 32'(PROG_LEN));
  assign w_fault = w_uflow | w_ovr;

  // Sequencing state, PC, stack pointers and retire counter.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= S_RESET;
      r_pc    <= '0;
      r_sp    <= '0;
      r_top   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_RESET: r_state <= S_RUN;
        S_RUN: begin
          if (w_fault) begin
            r_state <= S_FAULT;
          end else begin
            r_pc <= w_next;
            if (w_halt)
              r_state <= S_HALT;
            if (r_cnt != 16'hFFFF)
              r_cnt <= r_cnt + 16'd1;
            if (w_push) begin
              r_top <= r_top + 1'b1;
              if (r_sp != SP_MAX)
                r_sp <= r_sp + 1'b1;
            end
            if (w_pop) begin
              r_top <= w_top_m1;
              r_sp  <= r_sp - 1'b1;
            end
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Return-stack storage; circular so overflow overwrites the oldest link.
  always_ff @(posedge CLK) begin
    if (!reset && w_run && w_push && !w_fault)
      r_stack[r_top] <= w_pc_inc;
  end

  assign PC          = r_pc;
  assign sp          = r_sp;
  assign instr_count = r_cnt;
  assign DONE        = (r_state == S_HALT) || (r_state == S_FAULT);
  assign FAULT       = (r_state == S_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed control vectors,
// expected post-edge state queued by stimulus, checked by a monitor.
module tb_fetch_sequencer;

  logic        CLK;
  logic        reset;
  logic        Branch_abs, Branch_rel_z, Branch_rel_nz;
  logic        Call, Ret, Halt, ALU_zero;
  logic [15:0] Target;
  logic [15:0] PC;
  logic        DONE, FAULT;
  logic [15:0] instr_count;
  logic [2:0]  sp;

  fetch_sequencer #(.PC_W(16), .PROG_LEN(1024), .STACK_DEPTH(4)) dut (
    .CLK(CLK), .reset(reset),
    .Branch_abs(Branch_abs), .Branch_rel_z(Branch_rel_z),
    .Branch_rel_nz(Branch_rel_nz), .Call(Call), .Ret(Ret),
    .Halt(Halt), .ALU_zero(ALU_zero), .Target(Target),
    .PC(PC), .DONE(DONE), .FAULT(FAULT),
    .instr_count(instr_count), .sp(sp)
  );

  localparam logic [7:0] N   = 8'h00;
  localparam logic [7:0] R   = 8'h80;
  localparam logic [7:0] H   = 8'h40;
  localparam logic [7:0] RET = 8'h20;
  localparam logic [7:0] CL  = 8'h10;
  localparam logic [7:0] AB  = 8'h08;
  localparam logic [7:0] RZ  = 8'h04;
  localparam logic [7:0] RNZ = 8'h02;
  localparam logic [7:0] Z   = 8'h01;

  typedef struct {
    logic [15:0] pc;
    int          sp;
    int          cnt;
    logic        d;
    logic        f;
    int          id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic cyc(input logic [7:0] c, input logic [15:0] tgt,
                     input logic [15:0] epc, input int esp,
                     input int ecnt, input logic ed, input logic ef);
    exp_t e;
    @(negedge CLK);
    reset         = c[7];
    Halt          = c[6];
    Ret           = c[5];
    Call          = c[4];
    Branch_abs    = c[3];
    Branch_rel_z  = c[2];
    Branch_rel_nz = c[1];
    ALU_zero      = c[0];
    Target        = tgt;
    e.pc = epc; e.sp = esp; e.cnt = ecnt;
    e.d = ed; e.f = ef; e.id = vec;
    vec++;
    q.push_back(e);
  endtask

  task automatic rst_seq();
    cyc(R, 16'd0, 16'd0, 0, 0, 1'b0, 1'b0);
    cyc(R, 16'd0, 16'd0, 0, 0, 1'b0, 1'b0);
    cyc(N, 16'd0, 16'd0, 0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: compare DUT state just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (PC !== e.pc || int'(sp) != e.sp ||
            int'(instr_count) != e.cnt ||
            DONE !== e.d || FAULT !== e.f) begin
          errors++;
          $display("FAIL vec%0d got pc=%0d sp=%0d cnt=%0d done=%b fault=%b want pc=%0d sp=%0d cnt=%0d done=%b fault=%b",
                   e.id, PC, sp, instr_count, DONE, FAULT,
                   e.pc, e.sp, e.cnt, e.d, e.f);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; Halt = 1'b0; Ret = 1'b0; Call = 1'b0;
    Branch_abs = 1'b0; Branch_rel_z = 1'b0; Branch_rel_nz = 1'b0;
    ALU_zero = 1'b0; Target = '0;

    // Straight-line run then Halt at PC=5; frozen afterwards.
    rst_seq();
    for (int i = 1; i <= 5; i++)
      cyc(N, 16'd0, 16'(i), 0, i, 1'b0, 1'b0);
    cyc(H, 16'd0, 16'd5, 0, 6, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(8'(i * 7) & 8'h7F, 16'd3, 16'd5, 0, 6, 1'b1, 1'b0);

    // Relative branches (reset out of HALTED).
    rst_seq();
    cyc(AB, 16'd20, 16'd20, 0, 1, 1'b0, 1'b0);
    cyc(RNZ, 16'hFFEE, 16'd2, 0, 2, 1'b0, 1'b0);
    cyc(RZ, 16'd99, 16'd3, 0, 3, 1'b0, 1'b0);
    cyc(RZ | RNZ | Z, 16'd4, 16'd7, 0, 4, 1'b0, 1'b0);
    cyc(RNZ | Z, 16'd50, 16'd8, 0, 5, 1'b0, 1'b0);
    cyc(RZ | Z, 16'hFFFE, 16'd6, 0, 6, 1'b0, 1'b0);

    // Nested calls, then call immediately followed by return.
    rst_seq();
    cyc(AB, 16'd10, 16'd10, 0, 1, 1'b0, 1'b0);
    cyc(CL, 16'd102, 16'd102, 1, 2, 1'b0, 1'b0);
    cyc(CL, 16'd150, 16'd150, 2, 3, 1'b0, 1'b0);
    cyc(RET, 16'd0, 16'd103, 1, 4, 1'b0, 1'b0);
    cyc(RET, 16'd0, 16'd11, 0, 5, 1'b0, 1'b0);
    cyc(CL, 16'd200, 16'd200, 1, 6, 1'b0, 1'b0);
    cyc(RET, 16'd0, 16'd12, 0, 7, 1'b0, 1'b0);

    // Stack overflow wraps; fifth Ret underflows.
    rst_seq();
    cyc(CL, 16'd100, 16'd100, 1, 1, 1'b0, 1'b0);
    cyc(CL, 16'd200, 16'd200, 2, 2, 1'b0, 1'b0);
    cyc(CL, 16'd300, 16'd300, 3, 3, 1'b0, 1'b0);
    cyc(CL, 16'd400, 16'd400, 4, 4, 1'b0, 1'b0);
    cyc(CL, 16'd500, 16'd500, 4, 5, 1'b0, 1'b0);
    cyc(RET, 16'd0, 16'd401, 3, 6, 1'b0, 1'b0);
    cyc(RET, 16'd0, 16'd301, 2, 7, 1'b0, 1'b0);
    cyc(RET, 16'd0, 16'd201, 1, 8, 1'b0, 1'b0);
    cyc(RET, 16'd0, 16'd101, 0, 9, 1'b0, 1'b0);
    cyc(RET, 16'd0, 16'd101, 0, 9, 1'b1, 1'b1);
    cyc(N, 16'd0, 16'd101, 0, 9, 1'b1, 1'b1);
    cyc(CL, 16'd5, 16'd101, 0, 9, 1'b1, 1'b1);

    // Overrun via Branch_abs to PROG_LEN.
    rst_seq();
    cyc(AB, 16'd1023, 16'd1023, 0, 1, 1'b0, 1'b0);
    cyc(AB, 16'd1024, 16'd1023, 0, 1, 1'b1, 1'b1);

    // Overrun via fall-through past the last address.
    rst_seq();
    cyc(AB, 16'd1023, 16'd1023, 0, 1, 1'b0, 1'b0);
    cyc(N, 16'd0, 16'd1023, 0, 1, 1'b1, 1'b1);

    // Halt beats overrun on the last address.
    rst_seq();
    cyc(AB, 16'd1023, 16'd1023, 0, 1, 1'b0, 1'b0);
    cyc(H | CL | AB, 16'd1024, 16'd1023, 0, 2, 1'b1, 1'b0);

    // Halt beats Call and Branch_abs; sp unchanged.
    rst_seq();
    cyc(CL, 16'd30, 16'd30, 1, 1, 1'b0, 1'b0);
    cyc(H | CL | AB, 16'd60, 16'd30, 1, 2, 1'b1, 1'b0);
    cyc(RET, 16'd0, 16'd30, 1, 2, 1'b1, 1'b0);

    // Reset mid-run at PC=57, sp=2, instr_count=40.
    rst_seq();
    cyc(CL, 16'd20, 16'd20, 1, 1, 1'b0, 1'b0);
    cyc(CL, 16'd40, 16'd40, 2, 2, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++)
      cyc(AB, 16'd40, 16'd40, 2, 3 + i, 1'b0, 1'b0);
    for (int i = 1; i <= 17; i++)
      cyc(N, 16'd0, 16'(40 + i), 2, 23 + i, 1'b0, 1'b0);
    cyc(R, 16'd0, 16'd0, 0, 0, 1'b0, 1'b0);
    cyc(N, 16'd0, 16'd0, 0, 0, 1'b0, 1'b0);
    cyc(N, 16'd0, 16'd1, 0, 1, 1'b0, 1'b0);
    cyc(RET, 16'd0, 16'd1, 0, 1, 1'b1, 1'b1);

    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch-sequencing stage that sits directly upstream of the instruction ROM and feeds the datapath its instruction address each cycle. It resolves relative, absolute, call and return control flow. It keeps a small hardware return stack so function calls no longer need a hard-coded PC target. It also tracks run/halt/fault state, raises DONE, and counts retired instructions for the test harness.

## Interface
Parameters:
- PC_W, 16, program-counter width in bits.
- PROG_LEN, 1024, number of valid instruction words; the last valid address is PROG_LEN-1.
- STACK_DEPTH, 4, return-stack entries; must be a power of two, at least 2.

Ports:
- CLK, input, 1, the single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high; the top level drives it from START.
- Branch_abs, input, 1, PC <= Target.
- Branch_rel_z, input, 1, PC <= PC + Target when ALU_zero=1.
- Branch_rel_nz, input, 1, PC <= PC + Target when ALU_zero=0.
- Call, input, 1, push PC+1 onto the return stack; PC <= Target.
- Ret, input, 1, pop the return stack into PC.
- Halt, input, 1, the current instruction is the final one.
- ALU_zero, input, 1, registered zero flag from the ALU flag register.
- Target, input, PC_W, branch offset (two's complement) or absolute/call address from the branch LUTs.
- PC, output, PC_W, current instruction address to the instruction ROM.
- DONE, output, 1, program finished (halted or faulted).
- FAULT, output, 1, return-stack underflow or PC overrun occurred.
- instr_count, output, 16, retired-instruction counter.
- sp, output, clog2(STACK_DEPTH)+1, current return-stack occupancy (0..STACK_DEPTH).

## Operation
- States: RESET, RUN, HALTED, FAULTED.
- DONE = (state==HALTED) | (state==FAULTED).
- FAULT = (state==FAULTED).
- While reset=1:
  - state=RESET, PC=0, sp=0, instr_count=0, DONE=0, FAULT=0.
  - Stack contents are don't-care.
- RESET moves to RUN on the first edge with reset=0; PC stays 0.
- In RUN, every cycle retires exactly one instruction: instr_count increments, saturating at 0xFFFF.
- Next-PC priority in RUN, highest first; only the winner takes effect:
  1. Halt: PC holds; state becomes HALTED.
  2. Ret:
     - sp=0 → state becomes FAULTED, PC holds.
     - Otherwise PC <= top of stack, sp decrements.
  3. Call:
     - Stack entry at sp <= PC+1; PC <= Target; sp increments.
     - When sp=STACK_DEPTH, the entry is written circularly over the oldest, and sp stays at STACK_DEPTH (a silent overflow, not a fault).
  4. Branch_abs: PC <= Target.
  5. Branch_rel_z and ALU_zero=1: PC <= PC + Target.
  6. Branch_rel_nz and ALU_zero=0: PC <= PC + Target.
  7. Otherwise: PC <= PC+1.
- A relative branch whose condition is false falls through to PC+1.
- If Branch_rel_z and Branch_rel_nz are both set, exactly one is taken, chosen by ALU_zero.
- Arithmetic:
  - PC + Target is modulo 2^PC_W; Target is sign-interpreted for relative branches, unsigned for abs/call.
  - PC+1 is modulo 2^PC_W.
- Overrun: if the resolved next PC is ≥ PROG_LEN from any source, state becomes FAULTED and PC holds its current value.
  - Halt takes precedence over overrun on the same cycle.
- HALTED and FAULTED:
  - PC, sp, instr_count and stack are frozen.
  - All control inputs are ignored.
  - The only exit is reset.
- Reset asserted mid-RUN or mid-HALT wins on that edge: full reset values apply next cycle, and stack occupancy is discarded.

## Timing
- PC is registered. The ROM is combinational, so the instruction at PC is decoded and executed in the same cycle; control inputs are sampled at the edge that ends it.
- Branch/call/return latency is 1 cycle: the target is on PC at the next cycle. There are no delay slots and no bubbles.
- DONE/FAULT rise one cycle after the edge that samples Halt or the faulting condition, then stay high.
- Retired-instruction counting:
  - instr_count includes the Halt instruction.
  - A faulting Ret or overrun instruction is not counted.
- Return-stack data written by Call is readable by a Ret in the very next cycle.

## Test plan
- Straight-line run: reset for 2 cycles, then 5 idle cycles, then Halt at PC=5 → PC sequence 0,1,2,3,4,5; DONE=1 from the following cycle; instr_count=6; PC frozen at 5 for 10 further cycles.
- Relative branches:
  - At PC=20, Branch_rel_nz with Target=-18 (0xFFEE) and ALU_zero=0 → PC=2.
  - At PC=2, Branch_rel_z with ALU_zero=0 → PC=3.
  - Both rel strobes with ALU_zero=1, Target=4, at PC=3 → PC=7.
- Nested calls: Call Target=102 at PC=10 → PC=102, sp=1; Call Target=150 → PC=150, sp=2; Ret → PC=103, sp=1; Ret → PC=11, sp=0.
- Overflow/underflow:
  - 5 Calls with STACK_DEPTH=4 → sp stays 4; 4 Rets return the 4 most recent links.
  - A 5th Ret → FAULT=1 and DONE=1 next cycle; instr_count excludes that Ret.
- Overrun and priority:
  - Branch_abs with Target=PROG_LEN → FAULTED, PC unchanged.
  - Halt+Call+Branch_abs in the same cycle → HALTED, PC unchanged, sp unchanged.
- Reset mid-run: assert reset at PC=57 with sp=2 and instr_count=40 → next cycle PC=0, sp=0, instr_count=0, DONE=0; execution resumes from 0 after release.
